// File: rtl/distribute_pkg.sv
// Shared command encodings and entry layout for the 1x2 distribution path.
// Used by both the ingress sequencer and distribute_1x2_seq.
package distribute_pkg;

    localparam logic [1:0] CMD_NA   = 2'b00;
    localparam logic [1:0] CMD_LOW  = 2'b01;
    localparam logic [1:0] CMD_HIGH = 2'b10;
    localparam logic [1:0] CMD_DUP  = 2'b11;

    localparam int ENTRY_DATA_WIDTH = 32;

    typedef struct packed {
        logic [1:0]                  dest;
        logic [ENTRY_DATA_WIDTH-1:0] data;
    } entry_t;

    // A word may issue only if none of the branches it targets is stalled.
    function automatic logic dest_clear(input logic [1:0] dest, input logic [1:0] stall);
        return (dest & stall) == CMD_NA;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/distribute_1x2_ingress_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Full/empty come from the count; pointers wrap naturally (DEPTH is a power of 2).
module fifo_sync_seq #(
    parameter int DATA_WIDTH = 34,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/distribute_1x2_ingress.sv
// Ingress buffer for distribute_1x2_seq: queues destination-tagged words and
// issues each one only when all of its target branches are unstalled.
module distribute_1x2_ingress
    import distribute_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 2,
    parameter int FIFO_DEPTH     = 4,
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [DATA_WIDTH-1:0]     i_data_bus,
    input  logic [COMMMAND_WIDTH-1:0] i_dest,
    input  logic                      i_en,
    input  logic [1:0]                i_branch_stall,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data_bus,
    output logic [COMMMAND_WIDTH-1:0] o_cmd,
    output logic                      o_en,
    output logic [CW-1:0]             o_count,
    output logic [15:0]               o_drop_cnt
);

    typedef struct packed {
        logic [COMMMAND_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]     data;
    } slot_t;

    slot_t                     push_slot, head_slot;
    logic                      fifo_full, fifo_empty;
    logic                      accept, push, drop, issue;
    logic                      o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]     o_data_bus_q, o_data_bus_d;
    logic [COMMMAND_WIDTH-1:0] o_cmd_q, o_cmd_d;
    logic                      o_en_q, o_en_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    // Handshake: a word transfers on any edge where i_valid && i_ready; i_ready
    // depends only on reset and current occupancy, never on a same-cycle pop.
    assign i_ready   = !rst && !fifo_full;
    assign push_slot = '{dest: i_dest, data: i_data_bus};

    fifo_sync_seq #(
        .DATA_WIDTH ($bits(slot_t)),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_slot),
        .pop       (issue),
        .head_data (head_slot),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_count)
    );

    always_comb begin
        accept       = i_valid && i_ready;
        push         = accept && (i_dest != CMD_NA);
        drop         = accept && (i_dest == CMD_NA);
        issue        = !rst && !fifo_empty && i_en && dest_clear(head_slot.dest, i_branch_stall);
        o_valid_d    = issue;
        o_data_bus_d = issue ? head_slot.data : '0;
        o_cmd_d      = issue ? head_slot.dest : CMD_NA;
        o_en_d       = i_en;
        drop_cnt_d   = drop ? sat_inc16(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q    <= 1'b0;
            o_data_bus_q <= '0;
            o_cmd_q      <= CMD_NA;
            o_en_q       <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            o_valid_q    <= o_valid_d;
            o_data_bus_q <= o_data_bus_d;
            o_cmd_q      <= o_cmd_d;
            o_en_q       <= o_en_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data_bus = o_data_bus_q;
    assign o_cmd      = o_cmd_q;
    assign o_en       = o_en_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_distribute_1x2_ingress.sv
// Randomized and directed bench for distribute_1x2_ingress with a queue-based
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_distribute_1x2_ingress;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data_bus;
    logic [1:0]    i_dest;
    logic          i_en;
    logic [1:0]    i_branch_stall;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic [1:0]    o_cmd;
    logic          o_en;
    logic [2:0]    o_count;
    logic [15:0]   o_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queued words, expected outputs, drop count, registered enable.
    logic [DW+1:0] mq[$];
    logic [DW+1:0] exp_q[$];
    int            m_drop = 0;
    logic          m_en   = 1'b0;

    distribute_1x2_ingress #(
        .DATA_WIDTH     (DW),
        .COMMMAND_WIDTH (2),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_data_bus     (i_data_bus),
        .i_dest         (i_dest),
        .i_en           (i_en),
        .i_branch_stall (i_branch_stall),
        .o_valid        (o_valid),
        .o_data_bus     (o_data_bus),
        .o_cmd          (o_cmd),
        .o_en           (o_en),
        .o_count        (o_count),
        .o_drop_cnt     (o_drop_cnt)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words issue in order when the head's targets are unstalled.
    always @(posedge clk) begin
        bit acc, iss;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_drop = 0;
            m_en   = 1'b0;
        end else begin
            acc  = i_valid && (mq.size() < DEPTH);
            iss  = (mq.size() > 0) && i_en && ((mq[0][DW+1:DW] & i_branch_stall) == 2'b00);
            m_en = i_en;
            if (iss) exp_q.push_back(mq.pop_front());
            if (acc) begin
                if (i_dest == 2'b00) m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
                else                 mq.push_back({i_dest, i_data_bus});
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [DW+1:0] e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("i_ready", i_ready, (!rst && mq.size() < DEPTH));
            check("o_count", o_count, mq.size());
            check("o_drop_cnt", o_drop_cnt, m_drop);
            check("o_en", o_en, m_en);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_o_valid", o_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("o_data_bus", o_data_bus, e[DW-1:0]);
                    check("o_cmd", o_cmd, e[DW+1:DW]);
                end
            end else begin
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    check("missing_o_valid", o_valid, 1);
                end
                check("idle_data", o_data_bus, 0);
                check("idle_cmd", o_cmd, 0);
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] dst);
        int waited = 0;
        i_valid    = 1'b1;
        i_data_bus = d;
        i_dest     = dst;
        while (!i_ready && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("send_ready_timeout", i_ready, 1);
        @(posedge clk);
        #2;
        i_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        i_valid        = 1'b1;
        i_data_bus     = 32'hDEAD_BEEF;
        i_dest         = 2'b01;
        i_en           = 1'b1;
        i_branch_stall = 2'b00;
        idle(2);
        rst     = 1'b0;
        i_valid = 1'b0;
        idle(1);
        check("post_reset_ready", i_ready, 1);
        check("post_reset_count", o_count, 0);

        send(32'hAAAA_AAAA, 2'b01);
        idle(3);

        i_branch_stall = 2'b11;
        for (int k = 1; k <= 4; k++) send(DW'(k), 2'b11);
        i_valid    = 1'b1;
        i_data_bus = 32'd5;
        i_dest     = 2'b11;
        idle(3);
        check("fill_count", o_count, 4);
        check("fill_ready", i_ready, 0);
        i_branch_stall = 2'b00;
        send(32'd5, 2'b11);
        idle(8);

        i_branch_stall = 2'b01;
        send(32'h10, 2'b10);
        send(32'h11, 2'b11);
        idle(4);
        check("partial_held", o_count, 1);
        i_branch_stall = 2'b00;
        idle(4);

        for (int k = 0; k < 3; k++) send(DW'(32'h900 + k), 2'b00);
        idle(2);
        check("drop_three", o_drop_cnt, 3);
        i_valid    = 1'b1;
        i_dest     = 2'b00;
        i_data_bus = 32'h0;
        repeat (70000) @(posedge clk);
        #2;
        i_valid = 1'b0;
        idle(2);
        check("drop_saturated", o_drop_cnt, 16'hFFFF);

        for (int c = 0; c < 400; c++) begin
            i_valid        = ($urandom_range(0, 1) == 1);
            i_data_bus     = $urandom;
            i_dest         = 2'($urandom_range(0, 3));
            i_en           = ($urandom_range(0, 7) != 0);
            i_branch_stall = 2'($urandom_range(0, 3));
            idle(1);
        end
        i_valid        = 1'b0;
        i_en           = 1'b1;
        i_branch_stall = 2'b00;
        idle(10);

        i_branch_stall = 2'b11;
        for (int k = 0; k < 3; k++) send(DW'(32'h100 + k), 2'b01);
        i_en           = 1'b0;
        i_branch_stall = 2'b00;
        idle(3);
        check("disabled_o_en", o_en, 0);
        send(32'h103, 2'b01);
        check("disabled_push_count", o_count, 4);
        rst = 1'b1;
        idle(1);
        rst  = 1'b0;
        i_en = 1'b1;
        check("midreset_count", o_count, 0);
        idle(6);

        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
